// File: rtl/fan_drv.sv
// -----------------------------------------------------------------------------
// fan_drv -- fan actuator driver
//
// Turns the fan controller's level request into a soft-started and
// soft-stopped PWM drive. Once the fan reaches full speed it must stay there
// for a minimum on-time before it may ramp down. The driver state is reported
// back so the controller can see what the fan is actually doing.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   fan_on       in   on/off request (level, sampled every clk)
//   pwm_out      out  registered PWM drive to the fan
//   duty         out  current ramp duty (latched into the PWM at period end)
//   fan_state    out  00 OFF, 01 RAMP_UP, 10 ON, 11 RAMP_DOWN
//   fan_running  out  high only while in ON
//
// There is no valid/ready handshake on this block: fan_on is a level that is
// re-evaluated on every clock edge and is never latched.
// -----------------------------------------------------------------------------
module fan_drv #(
    parameter int PWM_W       = 4,
    parameter int MAX_DUTY    = 12,
    parameter int DUTY_STEP   = 1,
    parameter int STEP_CYCLES = 4,
    parameter int MIN_ON      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fan_on,
    output logic             pwm_out,
    output logic [PWM_W-1:0] duty,
    output logic [1:0]       fan_state,
    output logic             fan_running
);

    // Counter widths; kept at least one bit so degenerate parameters still elaborate.
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int MW = (MIN_ON > 0) ? $clog2(MIN_ON + 1) : 1;

    localparam logic [PWM_W-1:0] MAX_N     = PWM_W'(MAX_DUTY);
    localparam logic [PWM_W-1:0] STEP_N    = PWM_W'(DUTY_STEP);
    localparam logic [PWM_W:0]   MAX_WIDE  = (PWM_W + 1)'(MAX_DUTY);
    localparam logic [PWM_W:0]   STEP_WIDE = (PWM_W + 1)'(DUTY_STEP);
    localparam logic [PWM_W-1:0] PWM_LAST  = {PWM_W{1'b1}};
    localparam logic [SW-1:0]    STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [MW-1:0]    MIN_LOAD  = MW'(MIN_ON);

    typedef enum logic [1:0] {
        ST_OFF       = 2'b00,
        ST_RAMP_UP   = 2'b01,
        ST_ON        = 2'b10,
        ST_RAMP_DOWN = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [SW-1:0]    step_cnt_q, step_cnt_d;
    logic [MW-1:0]    min_cnt_q, min_cnt_d;
    logic             running_q, running_d;

    logic [PWM_W-1:0] pwm_cnt_q;
    logic [PWM_W-1:0] applied_q;
    logic             pwm_q;

    logic             step_hit;
    logic [PWM_W:0]   duty_up;

    // ------------------------------------------------------------------
    // Ramp / state machine: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        step_cnt_d = step_cnt_q;
        min_cnt_d  = min_cnt_q;
        step_hit   = (step_cnt_q == STEP_LAST);
        // One bit wider so the increment cannot wrap before the clamp.
        duty_up    = {1'b0, duty_q} + STEP_WIDE;

        case (state_q)
            ST_OFF: begin
                duty_d     = '0;
                step_cnt_d = '0;
                if (fan_on) begin
                    state_d = ST_RAMP_UP;
                end
            end

            ST_RAMP_UP: begin
                if (!fan_on) begin
                    // Abort wins over a coincident step: no increment here.
                    state_d    = ST_RAMP_DOWN;
                    step_cnt_d = '0;
                end else if (step_hit) begin
                    step_cnt_d = '0;
                    if (duty_up >= MAX_WIDE) begin
                        duty_d    = MAX_N;
                        state_d   = ST_ON;
                        min_cnt_d = MIN_LOAD;
                    end else begin
                        duty_d = duty_up[PWM_W-1:0];
                    end
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end

            ST_ON: begin
                duty_d     = MAX_N;
                step_cnt_d = '0;
                if (!fan_on && (min_cnt_q == '0)) begin
                    state_d = ST_RAMP_DOWN;
                end else if (min_cnt_q != '0) begin
                    min_cnt_d = min_cnt_q - 1'b1;
                end
            end

            ST_RAMP_DOWN: begin
                if (fan_on) begin
                    // Resume from the current duty, not from zero.
                    state_d    = ST_RAMP_UP;
                    step_cnt_d = '0;
                end else if (step_hit) begin
                    step_cnt_d = '0;
                    if ({1'b0, duty_q} <= STEP_WIDE) begin
                        duty_d  = '0;
                        state_d = ST_OFF;
                    end else begin
                        duty_d = duty_q - STEP_N;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d    = ST_OFF;
                duty_d     = '0;
                step_cnt_d = '0;
            end
        endcase

        running_d = (state_d == ST_ON);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            duty_q     <= '0;
            step_cnt_q <= '0;
            min_cnt_q  <= '0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            step_cnt_q <= step_cnt_d;
            min_cnt_q  <= min_cnt_d;
            running_q  <= running_d;
        end
    end

    // ------------------------------------------------------------------
    // PWM generator. The duty is only picked up on the last count of a
    // period so every period is generated from a single duty value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            applied_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (pwm_cnt_q == PWM_LAST) begin
                applied_q <= duty_q;
            end
            pwm_q <= (pwm_cnt_q < applied_q);
        end
    end

    assign pwm_out     = pwm_q;
    assign duty        = duty_q;
    assign fan_state   = state_q;
    assign fan_running = running_q;

endmodule

// File: tb/tb_fan_drv.sv
// -----------------------------------------------------------------------------
// tb_fan_drv -- self-checking bench for fan_drv
//
// A behavioural model (integer arithmetic on edge counts) runs alongside the
// DUT and a compare process checks every output on every falling edge.
// Directed scenarios add hand-computed literal expectations, followed by a
// randomized request sequence.
// -----------------------------------------------------------------------------
module tb_fan_drv;

    localparam int PWM_W       = 4;
    localparam int MAX_DUTY    = 12;
    localparam int DUTY_STEP   = 1;
    localparam int STEP_CYCLES = 4;
    localparam int MIN_ON      = 32;
    localparam int PERIOD      = 1 << PWM_W;

    logic             clk;
    logic             rst_n;
    logic             fan_on;
    logic             pwm_out;
    logic [PWM_W-1:0] duty;
    logic [1:0]       fan_state;
    logic             fan_running;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    // Model state: 0 OFF, 1 RAMP_UP, 2 ON, 3 RAMP_DOWN
    int m_st    = 0;
    int m_duty  = 0;
    int m_app   = 0;
    int m_cnt   = 0;
    int m_ramp  = 0;   // edges spent in the current ramp state
    int m_on    = 0;   // edges spent in ON
    int m_pwm   = 0;

    fan_drv #(
        .PWM_W      (PWM_W),
        .MAX_DUTY   (MAX_DUTY),
        .DUTY_STEP  (DUTY_STEP),
        .STEP_CYCLES(STEP_CYCLES),
        .MIN_ON     (MIN_ON)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fan_on     (fan_on),
        .pwm_out    (pwm_out),
        .duty       (duty),
        .fan_state  (fan_state),
        .fan_running(fan_running)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helper ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_st   = 0;
                m_duty = 0;
                m_app  = 0;
                m_cnt  = 0;
                m_ramp = 0;
                m_on   = 0;
                m_pwm  = 0;
            end else begin
                // PWM uses the pre-edge counter, applied duty and ramp duty.
                m_pwm = (m_cnt < m_app) ? 1 : 0;
                if (m_cnt == PERIOD - 1) m_app = m_duty;
                m_cnt = (m_cnt + 1) % PERIOD;

                case (m_st)
                    0: begin
                        m_duty = 0;
                        if (fan_on) begin
                            m_st   = 1;
                            m_ramp = 0;
                        end
                    end
                    1: begin
                        if (!fan_on) begin
                            m_st   = 3;
                            m_ramp = 0;
                        end else begin
                            m_ramp++;
                            if (m_ramp % STEP_CYCLES == 0) begin
                                m_duty = (m_duty + DUTY_STEP >= MAX_DUTY) ? MAX_DUTY : m_duty + DUTY_STEP;
                                if (m_duty == MAX_DUTY) begin
                                    m_st = 2;
                                    m_on = 0;
                                end
                            end
                        end
                    end
                    2: begin
                        m_duty = MAX_DUTY;
                        m_on++;
                        // Leaving is allowed once MIN_ON full edges have passed in ON.
                        if (!fan_on && m_on > MIN_ON) begin
                            m_st   = 3;
                            m_ramp = 0;
                        end
                    end
                    default: begin
                        if (fan_on) begin
                            m_st   = 1;
                            m_ramp = 0;
                        end else begin
                            m_ramp++;
                            if (m_ramp % STEP_CYCLES == 0) begin
                                m_duty = (m_duty - DUTY_STEP <= 0) ? 0 : m_duty - DUTY_STEP;
                                if (m_duty == 0) m_st = 0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("cyc_state",   int'(fan_state),   m_st);
            chk("cyc_duty",    int'(duty),        m_duty);
            chk("cyc_pwm",     int'(pwm_out),     m_pwm);
            chk("cyc_running", int'(fan_running), (m_st == 2) ? 1 : 0);
        end
    end

    // ---------------- driver tasks ----------------
    // Each call leaves time 2 units after a rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        repeat (n) begin
            cyc(1);
            c += int'(pwm_out);
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int hc;
        rst_n  = 1'b0;
        fan_on = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n   = 1'b1;
        started = 1;

        // Reset state
        chk("rst_state",   int'(fan_state),   0);
        chk("rst_duty",    int'(duty),        0);
        chk("rst_pwm",     int'(pwm_out),     0);
        chk("rst_running", int'(fan_running), 0);

        // Soft start to full speed
        fan_on = 1'b1;
        cyc(1);
        chk("t1_enter_state", int'(fan_state), 1);
        chk("t1_enter_duty",  int'(duty),      0);
        cyc(4);
        chk("t1_first_step",  int'(duty),      1);
        cyc(43);
        chk("t1_pre_on_state", int'(fan_state), 1);
        chk("t1_pre_on_duty",  int'(duty),      11);
        cyc(1);
        chk("t1_on_state",   int'(fan_state),   2);
        chk("t1_on_duty",    int'(duty),        12);
        chk("t1_on_running", int'(fan_running), 1);

        // Drop request 5 clocks into ON: minimum on-time holds it
        cyc(4);
        fan_on = 1'b0;
        cyc(28);
        chk("t2_min_hold_state", int'(fan_state), 2);
        cyc(1);
        chk("t2_rd_state",   int'(fan_state),   3);
        chk("t2_rd_duty",    int'(duty),        12);
        chk("t2_rd_running", int'(fan_running), 0);
        cyc(4);
        chk("t2_rd_first_step", int'(duty), 11);
        cyc(44);
        chk("t2_off_state", int'(fan_state), 0);
        chk("t2_off_duty",  int'(duty),      0);
        cyc(32);
        count_high(PERIOD, hc);
        chk("t2_off_pwm_high", hc, 0);

        // Abort ramp-up on an edge that would otherwise be a step
        fan_on = 1'b1;
        cyc(20);
        chk("t3_ramp_duty", int'(duty), 4);
        fan_on = 1'b0;
        cyc(1);
        chk("t3_abort_state", int'(fan_state), 3);
        chk("t3_abort_duty",  int'(duty),      4);
        cyc(16);
        chk("t3_off_state", int'(fan_state), 0);
        chk("t3_off_duty",  int'(duty),      0);

        // Full speed, PWM duty cycle, then re-request during ramp-down
        fan_on = 1'b1;
        cyc(49);
        chk("t4_on_state", int'(fan_state), 2);
        cyc(32);
        count_high(PERIOD, hc);
        chk("t4_on_pwm_high", hc, 12);
        fan_on = 1'b0;
        cyc(1);
        chk("t4_rd_state", int'(fan_state), 3);
        cyc(20);
        chk("t4_rd_duty7", int'(duty), 7);
        fan_on = 1'b1;
        cyc(1);
        chk("t4_reup_state", int'(fan_state), 1);
        chk("t4_reup_duty",  int'(duty),      7);
        cyc(4);
        chk("t4_reup_step",  int'(duty),      8);
        cyc(16);
        chk("t4_reon_state", int'(fan_state), 2);
        chk("t4_reon_duty",  int'(duty),      12);
        fan_on = 1'b0;
        cyc(90);
        chk("t4_final_off", int'(fan_state), 0);

        // Asynchronous reset in the middle of ramp-up
        fan_on = 1'b1;
        cyc(25);
        chk("t6_pre_rst_duty", int'(duty), 6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_state",   int'(fan_state),   0);
        chk("t6_async_duty",    int'(duty),        0);
        chk("t6_async_pwm",     int'(pwm_out),     0);
        chk("t6_async_running", int'(fan_running), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1);
        chk("t6_restart_state", int'(fan_state), 1);
        chk("t6_restart_duty",  int'(duty),      0);
        cyc(4);
        chk("t6_restart_step",  int'(duty),      1);

        // Randomized request pattern against the model
        repeat (40) begin
            fan_on = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 70));
        end
        fan_on = 1'b0;
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fan_drv.md
Name: fan_drv

Overview:
Fan actuator driver: the consuming end of the fan controller's `fan_on` command.
- Converts the on/off request into a soft-started, soft-stopped PWM drive with a minimum on-time.
- Reports its state back on the same fan interface, so the controller and bench can see what the fan is actually doing.
- Sits between the fan controller and the fan motor pin.

Parameters:
- PWM_W, 4: PWM counter/duty width; PWM period = 2^PWM_W clocks.
- MAX_DUTY, 12: full-speed duty (must be ≤ 2^PWM_W-1).
- DUTY_STEP, 1: duty change per ramp step.
- STEP_CYCLES, 4: clocks per ramp step (≥1).
- MIN_ON, 32: clocks the fan must stay in ON before ramp-down is allowed.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fan_on  in  1  request from fan controller; level, sampled every clk.
- pwm_out  out  1  registered PWM drive to the fan.
- duty  out  PWM_W  current ramp duty (target before period latch).
- fan_state  out  2  00 OFF, 01 RAMP_UP, 10 ON, 11 RAMP_DOWN.
- fan_running  out  1  high only in ON.

Behaviour:
- Reset (async, rst_n=0, also mid-operation): state=OFF, duty=0, applied duty=0, pwm_cnt=0, step_cnt=0, min_cnt=0, pwm_out=0, fan_running=0. The first edge after release behaves as from OFF.
- PWM counter:
  - pwm_cnt free-runs 0..2^PWM_W-1 and wraps to 0.
  - Applied duty is loaded from duty on the edge where pwm_cnt=2^PWM_W-1, so a period never sees a mid-period change.
  - pwm_out <= (pwm_cnt < applied duty), registered. Applied duty 0 gives constant 0.
- Ramp stepping:
  - step_cnt counts 0..STEP_CYCLES-1 while in a RAMP state. A step occurs on the edge where step_cnt=STEP_CYCLES-1; step_cnt then returns to 0.
  - step_cnt is cleared on every state change.
  - Step arithmetic is saturating: up clamps at MAX_DUTY, down clamps at 0. It is computed one bit wider than PWM_W to avoid wrap.
- FSM (all transitions on the clk edge where the condition is sampled):
  - OFF: duty=0. fan_on=1 -> RAMP_UP.
  - RAMP_UP:
    - On a step, duty += DUTY_STEP. If the result ≥ MAX_DUTY, duty=MAX_DUTY, go to ON and load min_cnt=MIN_ON on the same edge.
    - fan_on=0 -> RAMP_DOWN from the current duty. This takes priority over a same-edge step; no increment occurs.
  - ON:
    - duty held at MAX_DUTY; min_cnt decrements to 0 and holds.
    - fan_on=0 with min_cnt=0 -> RAMP_DOWN.
    - fan_on=0 with min_cnt>0 -> stay. The request is not latched; it is re-evaluated each cycle.
  - RAMP_DOWN:
    - On a step, duty -= DUTY_STEP. If the result ≤ 0, duty=0 and go to OFF on the same edge.
    - fan_on=1 -> RAMP_UP from the current duty. This takes priority over a same-edge step.
- fan_state, fan_running and duty are registered and reflect the state after each edge.
- Latency:
  - From fan_on rising, first duty increment is at edge +STEP_CYCLES.
  - Full speed is reached after ceil(MAX_DUTY/DUTY_STEP)·STEP_CYCLES edges.
  - pwm_out follows duty after the next period boundary plus 1 clock.

Test Plan:
1. Reset then fan_on=1 held (defaults):
   - fan_state=01 the edge after sampling.
   - duty goes 1,2,…,12 every 4 clocks.
   - fan_state=10 and fan_running=1 on the edge duty reaches 12 (48 clocks after entry).
   - pwm_out high 12 of every 16 clocks thereafter.
2. In ON, drop fan_on 5 clocks after entry:
   - Stays ON until min_cnt expires (32 clocks after ON entry).
   - Then fan_state=11 and duty steps 11…0 every 4 clocks.
   - OFF and pwm_out=0 for a full period after applied duty reaches 0.
3. Abort ramp-up:
   - fan_on=1 for 18 clocks: duty=4.
   - Then fan_on=0: RAMP_DOWN next edge, duty 3,2,1,0 at 4-clock steps, then OFF.
   - Check no increment occurs on the abort edge.
4. Re-request during ramp-down at duty=7:
   - Returns to RAMP_UP next edge.
   - duty continues 8…12 with no drop to 0.
5. Period latch:
   - Record pwm_cnt at the duty change.
   - pwm_out high-count in the current period equals the old applied duty.
   - The next period equals the new applied duty.
   - No period has a count other than one of the two.
6. Assert rst_n=0 mid-RAMP_UP (duty=6):
   - pwm_out, duty, fan_state, fan_running go 0 immediately, without waiting for clk.
   - After release with fan_on=1, the ramp restarts from duty 0.
